// File: rtl/lifo.sv
// ---------------------------------------------------------------------------
// lifo - synchronous last-in-first-out stack with registered read data.
//
// Buffers DATA_WIDTH-bit words and returns them newest-first. One push, one
// pop, or one combined push+pop is accepted every cycle with no stalls.
//
// Parameters
//   LIFO_DEPTH : number of storage entries (>= 2)
//   DATA_WIDTH : width of each stored word
//
// Ports
//   clk        : system clock, rising edge
//   asyn_n_rst : asynchronous active-low reset
//   push       : store data_in on top of the stack (ignored when full,
//                unless combined with a pop on a non-empty stack)
//   pop        : remove the top entry and present it on data_out
//                (ignored when empty)
//   data_in    : write data
//   data_out   : registered read data, holds the last popped word
//   full       : stack holds LIFO_DEPTH entries
//   empty      : stack holds no entries
// ---------------------------------------------------------------------------
module lifo #(
    parameter int LIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  asyn_n_rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int CNT_W = $clog2(LIFO_DEPTH + 1);
    localparam int AW    = $clog2(LIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [LIFO_DEPTH];
    logic [CNT_W-1:0]      cnt;

    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          pop_ok;
    logic          push_new;
    logic          replace;

    // Flags come straight from the count register, never from push/pop.
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);

    // top_idx is only used when the stack is non-empty and wr_idx only when
    // it is not full, so the truncations below never lose information.
    assign top_idx = AW'(cnt - ONE_C);
    assign wr_idx  = AW'(cnt);

    // A pop on a non-empty stack always succeeds. A push adds a new entry
    // only when it is not paired with a successful pop; a push+pop on an
    // empty stack degrades to a plain push. A push+pop on a non-empty stack
    // overwrites the current top in place, keeping the count unchanged.
    assign pop_ok   = pop && !empty;
    assign push_new = push && !pop_ok && !full;
    assign replace  = push && pop_ok;

    // Storage: intentionally not reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_new) begin
            mem[wr_idx] <= data_in;
        end else if (replace) begin
            mem[top_idx] <= data_in;
        end
    end

    // Occupancy count and registered read data.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            cnt      <= '0;
            data_out <= '0;
        end else begin
            if (push_new) begin
                cnt <= cnt + ONE_C;
            end else if (pop_ok && !push) begin
                cnt <= cnt - ONE_C;
            end
            if (pop_ok) begin
                data_out <= mem[top_idx];
            end
        end
    end

endmodule

// File: tb/tb_lifo.sv
// ---------------------------------------------------------------------------
// tb_lifo - self-checking bench for lifo (LIFO_DEPTH=8, DATA_WIDTH=8).
// A queue-based reference stack is updated on every rising edge and compared
// with the DUT on every falling edge; directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_lifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          asyn_n_rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue, top of stack at the back.
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_dout = '0;

    lifo #(.LIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge asyn_n_rst) begin
        model_q.delete();
        model_dout = '0;
    end

    always @(posedge clk) begin
        if (asyn_n_rst) begin
            if (pop && model_q.size() > 0) begin
                model_dout = model_q.pop_back();
                if (push) model_q.push_back(data_in);
            end else if (push && model_q.size() < DEPTH) begin
                model_q.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        check("model_data_out", data_out, model_dout);
        check("model_full", full, model_q.size() == DEPTH);
        check("model_empty", empty, model_q.size() == 0);
        check("full_and_empty", full && empty, 1'b0);
    end

    task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
        @(negedge clk);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_pop [10];
        exp_pop = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd1};

        repeat (2) @(negedge clk);
        #1;
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_dout", data_out, 8'h00);
        asyn_n_rst = 1'b1;

        // Overflow: push 1..10, only 1..8 stored.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, DW'(i));
            if (i == 7) check("ovf_not_full_7", full, 1'b0);
            if (i == 8) check("ovf_full_8", full, 1'b1);
            if (i == 10) check("ovf_full_10", full, 1'b1);
            check("ovf_not_empty", empty, 1'b0);
        end

        // Underflow: ten pops, last two ignored.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("udf_dout", data_out, exp_pop[i]);
            if (i == 0) check("udf_full_drop", full, 1'b0);
            if (i == 6) check("udf_not_empty_7", empty, 1'b0);
            if (i >= 7) check("udf_empty", empty, 1'b1);
        end

        // Simultaneous push+pop on a non-empty stack.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        check("sim_dout", data_out, 8'h22);
        step(1'b0, 1'b1, 8'h00);
        check("sim_pop1", data_out, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        check("sim_pop2", data_out, 8'h11);
        check("sim_empty", empty, 1'b1);

        // Simultaneous push+pop on an empty stack acts as a push.
        step(1'b1, 1'b1, 8'h5A);
        check("sim_empty_dout_hold", data_out, 8'h11);
        check("sim_empty_not_empty", empty, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        check("sim_empty_pop", data_out, 8'h5A);

        // Asynchronous reset mid-operation.
        step(1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b0, 8'h00);
        asyn_n_rst = 1'b0;
        #1;
        check("arst_empty", empty, 1'b1);
        check("arst_full", full, 1'b0);
        check("arst_dout", data_out, 8'h00);
        @(negedge clk);
        #1;
        asyn_n_rst = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_pop_dout", data_out, 8'h00);
        check("post_rst_pop_empty", empty, 1'b1);

        // Random traffic checked by the model process.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70, DW'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
